// File: rtl/i2s_slave.sv
// Philips I2S slave: receives left/right words on sdi and transmits on sdo,
// with sck/ws/sdi sampled in the clk domain through 2-flop synchronizers.
module i2s_slave #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sdi,
  output logic                  sdo,
  input  logic [DATA_WIDTH-1:0] data_send_left,
  input  logic [DATA_WIDTH-1:0] data_send_right,
  output logic [DATA_WIDTH-1:0] data_recv_left,
  output logic [DATA_WIDTH-1:0] data_recv_right,
  output logic                  recv_valid_left,
  output logic                  recv_valid_right
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                  sck_s1, sck_s2, sck_d;
  logic                  ws_s1, ws_s2;
  logic                  sdi_s1, sdi_s2;
  logic                  sck_rise, sck_fall;

  logic                  ws_prev, primed, locked, load_pending;
  logic [DATA_WIDTH-1:0] rx_shreg, tx_shreg, tx_hold;
  logic [CW-1:0]         rx_cnt, tx_cnt;

  logic [DATA_WIDTH-1:0] rx_shreg_nx, commit_word;
  logic [CW-1:0]         rx_cnt_nx;
  logic                  ws_change;

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_shreg_nx = rx_shreg;
    rx_cnt_nx   = rx_cnt;
    if (rx_cnt < CW'(DATA_WIDTH)) begin
      rx_shreg_nx = {rx_shreg[DATA_WIDTH-2:0], sdi_s2};
      rx_cnt_nx   = rx_cnt + CW'(1);
    end
    // Left-justify a short slot so the missing LSBs read as zero.
    commit_word = rx_shreg_nx << (CW'(DATA_WIDTH) - rx_cnt_nx);
    // primed masks the first rise after reset, which only loads ws_prev.
    ws_change   = sck_rise && primed && (ws_s2 != ws_prev);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all state here is plain registers (no memory arrays), so everything is reset.
      {sck_s1, sck_s2, sck_d} <= '0;
      {ws_s1, ws_s2}          <= '0;
      {sdi_s1, sdi_s2}        <= '0;
      ws_prev                 <= 1'b0;
      primed                  <= 1'b0;
      locked                  <= 1'b0;
      load_pending            <= 1'b0;
      rx_shreg                <= '0;
      rx_cnt                  <= '0;
      tx_shreg                <= '0;
      tx_cnt                  <= '0;
      tx_hold                 <= '0;
      sdo                     <= 1'b0;
      data_recv_left          <= '0;
      data_recv_right         <= '0;
      recv_valid_left         <= 1'b0;
      recv_valid_right        <= 1'b0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      ws_s1  <= ws;
      ws_s2  <= ws_s1;
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;

      recv_valid_left  <= 1'b0;
      recv_valid_right <= 1'b0;

      if (sck_rise) begin
        ws_prev <= ws_s2;
        primed  <= 1'b1;
        if (ws_change) begin
          // The bit sampled at this rise still belongs to the channel that just ended.
          if (locked) begin
            if (ws_prev) begin
              data_recv_right  <= commit_word;
              recv_valid_right <= 1'b1;
            end else begin
              data_recv_left  <= commit_word;
              recv_valid_left <= 1'b1;
            end
          end
          locked       <= 1'b1;
          rx_shreg     <= '0;
          rx_cnt       <= '0;
          tx_hold      <= ws_s2 ? data_send_right : data_send_left;
          load_pending <= 1'b1;
        end else begin
          rx_shreg <= rx_shreg_nx;
          rx_cnt   <= rx_cnt_nx;
        end
      end

      if (sck_fall && locked) begin
        if (load_pending) begin
          sdo          <= tx_hold[DATA_WIDTH-1];
          tx_shreg     <= tx_hold << 1;
          tx_cnt       <= CW'(1);
          load_pending <= 1'b0;
        end else if (tx_cnt < CW'(DATA_WIDTH)) begin
          sdo      <= tx_shreg[DATA_WIDTH-1];
          tx_shreg <= tx_shreg << 1;
          tx_cnt   <= tx_cnt + CW'(1);
        end else begin
          sdo <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave.sv
// Bench for i2s_slave: behaves as the I2S master, scoreboards received words
// and decodes sdo per slot against a model of the word captured at each ws change.
module tb_i2s_slave;

  localparam int DW = 24;

  typedef struct {
    int            nbits;
    logic [DW-1:0] l_in, r_in;
    logic [DW-1:0] send_l, send_r;
    logic [DW-1:0] exp_l, exp_r;
    logic [DW-1:0] exp_tx_l, exp_tx_r;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst, sck, ws, sdi, sdo;
  logic [DW-1:0] data_send_left, data_send_right;
  logic [DW-1:0] data_recv_left, data_recv_right;
  logic          recv_valid_left, recv_valid_right;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] q_l[$];
  logic [DW-1:0] q_r[$];
  logic [DW-1:0] last_exp_l = '0, last_exp_r = '0;
  logic          locked_m = 1'b0, tx_ok_m = 1'b0;
  logic [DW-1:0] tx_exp = '0;

  frame_t vec[5];

  i2s_slave #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .sck              (sck),
    .ws               (ws),
    .sdi              (sdi),
    .sdo              (sdo),
    .data_send_left   (data_send_left),
    .data_send_right  (data_send_right),
    .data_recv_left   (data_recv_left),
    .data_recv_right  (data_recv_right),
    .recv_valid_left  (recv_valid_left),
    .recv_valid_right (recv_valid_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (recv_valid_left) begin
        if (q_l.size() == 0) check("spurious_valid_left", 32'(recv_valid_left), 32'd0);
        else check("recv_left", 32'(data_recv_left), 32'(q_l.pop_front()));
      end
      if (recv_valid_right) begin
        if (q_r.size() == 0) check("spurious_valid_right", 32'(recv_valid_right), 32'd0);
        else check("recv_right", 32'(data_recv_right), 32'(q_r.pop_front()));
      end
    end
  end

  // One sck period: data and ws change at the fall, sdo is sampled at the rise.
  task automatic bit_period(input logic w, input logic d, output logic s);
    sck = 1'b0;
    ws  = w;
    sdi = d;
    repeat (8) @(negedge clk);
    s   = sdo;
    sck = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_recv_left", 32'(data_recv_left), 32'd0);
    check("rst_recv_right", 32'(data_recv_right), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_valids", 32'({recv_valid_left, recv_valid_right}), 32'd0);
    locked_m = 1'b0;
    tx_ok_m  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Drives one slot of channel ch; the last bit carries the ws change to the other channel.
  task automatic drive_slot(input logic ch, input logic [DW-1:0] word_in, input logic [DW-1:0] exp_rx,
                            input int nbits, input int rst_at, input int chg_at,
                            input logic [DW-1:0] chg_val, output logic [DW-1:0] dec);
    logic          ok, s, pad, exp_bit;
    logic [DW-1:0] cur_tx, exp_dec;
    string         tag;
    tag     = ch ? "right" : "left";
    ok      = tx_ok_m;
    cur_tx  = tx_exp;
    dec     = '0;
    exp_dec = '0;
    pad     = 1'b0;
    for (int j = 1; j <= nbits; j++) begin
      if (j == rst_at) begin
        pulse_reset();
        ok = 1'b0;
      end
      if (j == chg_at) data_send_left = chg_val;
      if (j == nbits) begin
        if (locked_m) begin
          if (ch) begin q_r.push_back(exp_rx); last_exp_r = exp_rx; end
          else    begin q_l.push_back(exp_rx); last_exp_l = exp_rx; end
        end
        locked_m = 1'b1;
        tx_ok_m  = 1'b1;
        tx_exp   = ch ? data_send_left : data_send_right;
      end
      bit_period((j == nbits) ? ~ch : ch, (j <= DW) ? word_in[DW-j] : 1'b0, s);
      exp_bit = (ok && j <= DW) ? cur_tx[DW-j] : 1'b0;
      if (j <= DW) begin
        dec[DW-j]     = s;
        exp_dec[DW-j] = exp_bit;
      end else begin
        pad = pad | s;
      end
    end
    check({"tx_word_", tag}, 32'(dec), 32'(exp_dec));
    if (nbits > DW) check({"tx_pad_", tag}, 32'(pad), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] dec;

    vec[0] = '{32, 24'h123456, 24'hABCDEF, 24'h5A5A5A, 24'h0F0F0F, 24'h123456, 24'hABCDEF, 24'h5A5A5A, 24'h0F0F0F};
    vec[1] = '{32, 24'h123456, 24'hABCDEF, 24'h5A5A5A, 24'h0F0F0F, 24'h123456, 24'hABCDEF, 24'h5A5A5A, 24'h0F0F0F};
    vec[2] = '{16, 24'h1234FF, 24'h00BEEF, 24'hA5C3E7, 24'h3C3C3C, 24'h123400, 24'h00BE00, 24'hA5C300, 24'h3C3C00};
    vec[3] = '{32, 24'hFFFFFF, 24'h000001, 24'h800001, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'h800001, 24'hFFFFFF};
    vec[4] = '{24, 24'h800000, 24'h7FFFFF, 24'hC0FFEE, 24'h123ABC, 24'h800000, 24'h7FFFFF, 24'hC0FFEE, 24'h123ABC};

    rst = 1'b1;
    sck = 1'b0;
    ws  = 1'b1;
    sdi = 1'b0;
    data_send_left  = '0;
    data_send_right = '0;
    repeat (4) @(negedge clk);
    check("reset_recv_left", 32'(data_recv_left), 32'd0);
    check("reset_recv_right", 32'(data_recv_right), 32'd0);
    check("reset_sdo", 32'(sdo), 32'd0);
    check("reset_valids", 32'({recv_valid_left, recv_valid_right}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // sck starts mid right slot: this partial word must never be committed.
    data_send_left  = vec[0].send_l;
    data_send_right = vec[0].send_r;
    drive_slot(1'b1, 24'h3C5A69, '0, 5, 0, 0, '0, dec);

    // Left word of frame k+1 is captured at the end of frame k's right slot.
    for (int k = 0; k < 5; k++) begin
      data_send_right = vec[k].send_r;
      data_send_left  = (k < 4) ? vec[k+1].send_l : vec[k].send_l;
      drive_slot(1'b0, vec[k].l_in, vec[k].exp_l, vec[k].nbits, 0, 0, '0, dec);
      check($sformatf("frame%0d_tx_left", k), 32'(dec), 32'(vec[k].exp_tx_l));
      drive_slot(1'b1, vec[k].r_in, vec[k].exp_r, vec[k].nbits, 0, 0, '0, dec);
      check($sformatf("frame%0d_tx_right", k), 32'(dec), 32'(vec[k].exp_tx_r));
    end

    // data_send_left changes mid-slot: the word in flight is unaffected.
    drive_slot(1'b0, 24'h654321, 24'h654321, 32, 0, 0, '0, dec);
    data_send_left = 24'h111111;
    drive_slot(1'b1, 24'h0A0B0C, 24'h0A0B0C, 32, 0, 0, '0, dec);
    drive_slot(1'b0, 24'h13579B, 24'h13579B, 32, 0, 12, 24'h222222, dec);
    check("midslot_change_current", 32'(dec), 32'h111111);
    drive_slot(1'b1, 24'h2468AC, 24'h2468AC, 32, 0, 0, '0, dec);
    drive_slot(1'b0, 24'hFEDCBA, 24'hFEDCBA, 32, 0, 0, '0, dec);
    check("midslot_change_next", 32'(dec), 32'h222222);
    drive_slot(1'b1, 24'h0F1E2D, 24'h0F1E2D, 32, 0, 0, '0, dec);

    // Reset mid-left-word, then relock and receive a full frame.
    data_send_right = 24'h5A5A5A;
    data_send_left  = 24'h0F0F0F;
    drive_slot(1'b0, 24'hDEAD01, 24'hDEAD01, 32, 10, 0, '0, dec);
    drive_slot(1'b1, 24'hBEEF02, 24'hBEEF02, 32, 0, 0, '0, dec);
    check("post_reset_tx_right", 32'(dec), 32'h5A5A5A);
    drive_slot(1'b0, 24'hCAFE03, 24'hCAFE03, 32, 0, 0, '0, dec);
    check("post_reset_tx_left", 32'(dec), 32'h0F0F0F);
    drive_slot(1'b1, 24'h00FACE, 24'h00FACE, 32, 0, 0, '0, dec);

    repeat (20) @(negedge clk);
    check("pending_left", 32'(q_l.size()), 32'd0);
    check("pending_right", 32'(q_r.size()), 32'd0);
    check("hold_left", 32'(data_recv_left), 32'(last_exp_l));
    check("hold_right", 32'(data_recv_right), 32'(last_exp_r));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_slave.md
I2S_SLAVE -- requirements
Module: i2s_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 24, audio word width in bits per channel.
REQ-002 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 sck  input  1  I2S bit clock from the external master; asynchronous to clk.
REQ-005 ws  input  1  word select from the master: 0 = left, 1 = right; changes on the sck falling edge.
REQ-006 sdi  input  1  serial data from the master; the slave samples it on sck rising edges.
REQ-007 sdo  output  1  serial data to the master; updated after sck falling edges.
REQ-008 data_send_left, data_send_right  input  DATA_WIDTH  words to transmit on sdo.
REQ-009 data_recv_left, data_recv_right  output  DATA_WIDTH  last complete received word per channel.
REQ-010 recv_valid_left, recv_valid_right  output  1  one-clk pulse when the matching data_recv register updates.

Function
REQ-011 sck, ws and sdi SHALL each pass through a 2-flop synchronizer; sck edges are detected from the synchronized value (rise = 0->1, fall = 1->0).
REQ-012 Operating constraint: each sck high and low phase SHALL last at least 4 clk cycles; behaviour outside this constraint is undefined.
REQ-013 Protocol is Philips I2S: MSB first, MSB one sck period after a ws transition, and ws leads data by one bit.
REQ-014 At each sck rise, ws_prev SHALL be compared with the synchronized ws and then updated; a mismatch is a "ws change".
REQ-015 The locked flag SHALL be 0 after reset and set at the first ws change.
- While unlocked: no commit, no valid pulse, sdo = 0.
REQ-016 At each sck rise, if rx_cnt < DATA_WIDTH, sdi SHALL be shifted into rx_shreg LSB-side and rx_cnt incremented; further bits in the slot are ignored.
REQ-017 A ws change at rise k SHALL first apply REQ-016 to bit k, which belongs to the previous channel.
- If locked before rise k: commit rx_shreg, left-shifted by (DATA_WIDTH - rx_cnt) so a short slot is zero-padded in the LSBs.
- Destination is data_recv_left if ws_prev was 0, otherwise data_recv_right.
- Pulse the matching recv_valid for exactly 1 clk cycle.
- Then clear rx_shreg and rx_cnt.
REQ-018 Commit latency SHALL be at most 4 clk cycles after the physical sck rising edge.
REQ-019 data_recv_* SHALL hold their value between commits.
REQ-020 At a ws change at rise k, the word to transmit SHALL be captured into tx_hold: data_send_left if the new ws is 0, data_send_right if it is 1. load_pending is then set.
- data_send_* changes at any other time SHALL NOT affect the word in flight.
REQ-021 At each sck fall while locked:
- If load_pending: sdo = tx_hold[MSB], tx_shreg = tx_hold << 1, tx_cnt = 1, load_pending cleared.
- Else if tx_cnt < DATA_WIDTH: sdo = tx_shreg[MSB], shift, tx_cnt++.
- Else: sdo = 0 (slot padding).
REQ-022 sdo SHALL change only in the clk cycle following a detected sck fall.
REQ-023 A ws change arriving before DATA_WIDTH bits have been sent SHALL truncate the current TX word; the new word starts at the next fall.
REQ-024 Both channels SHALL use identical logic; a frame with only one ws change still commits correctly.

Reset
REQ-025 When rst = 1 at a clk edge, the following SHALL clear to 0: all outputs, synchronizers, ws_prev, locked, rx/tx shift registers and counters, tx_hold, load_pending.
REQ-026 rst asserted mid-word SHALL discard the partial RX and TX words.
- After rst deasserts, the slave waits for a new ws change (REQ-015) before receiving or driving data.
REQ-027 The first sck rise after reset SHALL load ws_prev from ws without being treated as a ws change.

Verification
REQ-028 DATA_WIDTH=24; clk:sck ratio 16; 32-bit slots; master sends L=0x123456, R=0xABCDEF.
- Required: data_recv_left=0x123456 and data_recv_right=0xABCDEF, each with one valid pulse per frame.
REQ-029 data_send_left=0x5A5A5A, data_send_right=0x0F0F0F; master samples sdo on sck rises.
- Required: it decodes 0x5A5A5A (left) and 0x0F0F0F (right); slot bits 25-32 read as 0.
REQ-030 16-bit slots; master sends L=0x1234.
- Required: data_recv_left=0x123400; TX word truncated to its top 16 bits.
REQ-031 data_send_left changes from 0x111111 to 0x222222 mid-left-slot.
- Required: the current word is 0x111111; the next left word is 0x222222.
REQ-032 rst pulsed mid-left-word.
- Required: outputs are 0 the next cycle; no valid pulse and sdo = 0 until a ws change.
- Required: the first frame after that change decodes correctly.
REQ-033 Start sck in the middle of a right slot after reset.
- Required: no commit of the partial word; the first valid pulse is recv_valid_left after a complete left slot... more precisely, the first valid pulse occurs at the first ws change after lock, and it is recv_valid_right or recv_valid_left matching the channel just ended.
